// File: rtl/vref_meas_sched.sv
// Round-robin measurement scheduler for the shared reference/temperature sensing core.
// Define VREF_SCHED_TIMEOUT_EN to bound the wait for core_ready (err reports a timeout).
module vref_meas_sched #(
  parameter int RST_CYC = 4,
  parameter int WIN     = 64,
  parameter int CNT_W   = 7,
  parameter int TO_CYC  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             err,
  output logic             core_rst,
  input  logic             core_ready,
  input  logic             cmp
);

  // One shared down-counter covers the reset hold, the window and the ready timeout.
  localparam int TO_W  = $clog2(TO_CYC + 1);
  localparam int W_A   = (CNT_W > 8) ? CNT_W : 8;
  localparam int CYC_W = (W_A > TO_W) ? W_A : TO_W;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CYC_W-1:0] cyc_reg, cyc_next;
  logic [CNT_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] result_reg, result_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic             last_reg, last_next;
  logic             cmp_meta_reg, cmp_s_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_meta_reg <= 1'b0;
      cmp_s_reg    <= 1'b0;
    end else begin
      cmp_meta_reg <= cmp;
      cmp_s_reg    <= cmp_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cyc_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      gnt_reg    <= 2'b00;
      last_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      gnt_reg    <= gnt_next;
      last_reg   <= last_next;
    end
  end

`ifdef VREF_SCHED_TIMEOUT_EN
  logic err_reg, err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    gnt_next    = gnt_reg;
    last_next   = last_reg;
`ifdef VREF_SCHED_TIMEOUT_EN
    err_next    = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          // last_reg=1 means client 1 was served last, so client 0 wins a tie.
          if (req[0] && (!req[1] || last_reg)) begin
            gnt_next  = 2'b01;
            last_next = 1'b0;
          end else begin
            gnt_next  = 2'b10;
            last_next = 1'b1;
          end
          cyc_next   = CYC_W'(RST_CYC - 1);
          state_next = S_RST;
        end
      end
      S_RST: begin
        if (cyc_reg == '0) begin
          state_next = S_WAIT;
`ifdef VREF_SCHED_TIMEOUT_EN
          cyc_next   = CYC_W'(TO_CYC - 1);
`endif
        end else begin
          cyc_next = cyc_reg - 1'b1;
        end
      end
      S_WAIT: begin
        if (core_ready) begin
          acc_next   = '0;
          cyc_next   = CYC_W'(WIN - 1);
          state_next = S_SAMPLE;
        end
`ifdef VREF_SCHED_TIMEOUT_EN
        else if (cyc_reg == '0) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = S_DONE;
        end else begin
          cyc_next = cyc_reg - 1'b1;
        end
`endif
      end
      S_SAMPLE: begin
        if (cmp_s_reg && (acc_reg != '1)) acc_next = acc_reg + 1'b1;
        if (cyc_reg == '0) begin
          result_next = acc_next;
`ifdef VREF_SCHED_TIMEOUT_EN
          err_next    = 1'b0;
`endif
          state_next  = S_DONE;
        end else begin
          cyc_next = cyc_reg - 1'b1;
        end
      end
      S_DONE: begin
        gnt_next   = 2'b00;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign gnt      = gnt_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign result   = result_reg;
  assign core_rst = !((state_reg == S_WAIT) || (state_reg == S_SAMPLE));

endmodule

// File: doc/vref_meas_sched.md
# vref_meas_sched

Measurement scheduler for the shared switched-capacitor reference/temperature sensing core. It takes measurement requests from two clients and grants the core to one client at a time, round-robin. For each grant it parks and releases the core's reset, waits for the core to report ready, and counts comparator decisions over a fixed window. It then returns the count to the granted client with a one-cycle done pulse.

## Interface
- `RST_CYC`, 4: cycles the core is held in reset after a grant; range 1..255.
- `WIN`, 64: sampling window length in cycles; range 1..2^CNT_W−1.
- `CNT_W`, 7: result width; CNT_W ≥ clog2(WIN+1).
- `TO_CYC`, 255: maximum cycles to wait for `core_ready` (timeout feature only).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in 2: level request per client; held high until that client's `done`.
- `gnt` out 2: one-hot grant; all zero when idle.
- `busy` out 1: a transaction is in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse; `result` and `err` are valid in this cycle.
- `result` out CNT_W: count of comparator-high cycles in the window.
- `err` out 1: core failed to become ready (timeout feature only; else tied 0).
- `core_rst` out 1: reset to the sensing core; high parks the core.
- `core_ready` in 1: core setup complete (synchronous to `clk`).
- `cmp` in 1: raw comparator output, asynchronous to `clk`.

## Operation
- Reset values:
  - `gnt`=0, `busy`=0, `done`=0, `result`=0, `err`=0, `core_rst`=1.
  - Round-robin pointer → client 0 has priority.
  - cmp synchronizer = 0.
- `cmp` passes through a 2-flop synchronizer. Only the synchronized value `cmp_s` is counted.
- States: IDLE, RST, WAIT, SAMPLE, DONE.
- IDLE:
  - `core_rst`=1, `gnt`=0.
  - If any `req` is high: grant one client, load `RST_CYC−1` into the cycle counter, and go to RST.
  - With both requesting, the client that was not served last wins. The pointer updates at grant.
- RST:
  - `core_rst`=1, `gnt` held.
  - When the counter reaches 0, go to WAIT.
- WAIT:
  - `core_rst`=0.
  - When `core_ready`=1, clear the accumulator, load `WIN−1`, and go to SAMPLE.
- SAMPLE:
  - `core_rst`=0.
  - Each cycle the accumulator adds `cmp_s`, saturating at all-ones.
  - After exactly WIN sampled cycles, go to DONE.
  - A `core_ready` drop during SAMPLE is ignored.
- DONE:
  - `done`=1, `result` = accumulator.
  - `gnt` is still held this cycle. `core_rst` returns to 1.
  - Next cycle go to IDLE.
- `result` holds its value until the next `done`.
- `req` falling mid-transaction: the transaction still completes. `done` is still pulsed (abort is not supported).
- `req` still high in IDLE after `done`: treated as a new request. The other client wins if it is also requesting.
- `reset` mid-transaction: immediate return to IDLE with all reset values. No `done` is issued.

## Timing
- `req` sampled high at edge N → `gnt` and `busy` high after edge N; RST occupies cycles N+1..N+RST_CYC.
- Earliest `core_rst` fall: after edge N+RST_CYC.
- Minimum request-to-`done` latency, with `core_ready` already high: RST_CYC + 1 + WIN + 1 cycles.
- `cmp` to count latency: 2 cycles. The window counts `cmp_s`, i.e. `cmp` from 2 cycles earlier.
- Back-to-back throughput: at most one transaction per RST_CYC+WIN+3 cycles (IDLE costs 1 cycle).

## Configuration
- `VREF_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles. If `core_ready` is not seen within TO_CYC cycles, go to DONE with `err`=1 and `result`=0.
  - `err` is otherwise 0 on `done`.
- Undefined:
  - WAIT waits indefinitely.
  - `err` is a constant 0 and no timeout counter is built.

## Test plan
- Single request: `req`=01, `core_ready`=1, `cmp`=1 constant, defaults → `gnt`=01 and `done` 70 cycles after the req edge, `result`=64, `err`=0.
- Contention: `req`=11 held → grants alternate 01, 10, 01. Each completes with `done`, and `gnt` is never 11.
- Duty-cycle count: `cmp` toggles every cycle during the window → `result`=32 ±1. `core_rst`=1 in IDLE/RST/DONE only.
- Delayed ready: `core_ready` rises 20 cycles after `core_rst` falls → SAMPLE starts the cycle after `core_ready` is seen, and latency is +20.
- Timeout (`VREF_SCHED_TIMEOUT_EN`, TO_CYC=255): `core_ready`=0 → `done` with `err`=1 and `result`=0 after TO_CYC cycles in WAIT. Without the macro, `busy` stays high indefinitely.
- Reset mid-SAMPLE: assert `reset` → all outputs return to reset values the same cycle, no `done`, and the next grant goes to client 0.
